// File: rtl/dcache_direct_wb_if.sv
// Pipeline-side and block-memory-side signals of the direct-mapped write-back D-cache.
// slave = the cache itself, master = the core/memory environment driving it.
interface dcache_direct_wb_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache with zero-latency hits.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_direct_wb #(
    parameter int INDEX_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    dcache_direct_wb_if.slave   bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t             state;
    logic               valid [LINES];
    logic               dirty [LINES];
    logic [TAG_W-1:0]   tags  [LINES];
    logic [127:0]       data  [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         off;
    logic               req;
    logic               hit;

    assign idx     = bus.proc_addr[1+INDEX_W:2];
    assign req_tag = bus.proc_addr[29:2+INDEX_W];
    assign off     = bus.proc_addr[1:0];
    assign req     = bus.proc_read | bus.proc_write;
    assign hit     = valid[idx] && (tags[idx] == req_tag);

    // Stall and read data are combinational so a hit completes in the cycle it is presented.
    always_comb begin
        bus.proc_stall = 1'b0;
        bus.proc_rdata = data[idx][{off, 5'b0} +: 32];
        if (state != IDLE)
            bus.proc_stall = 1'b1;
        else if (req && !hit)
            bus.proc_stall = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                valid[i] <= 1'b0;
                dirty[i] <= 1'b0;
                tags[i]  <= '0;
                data[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (bus.proc_write) begin
                                data[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
                                dirty[idx]                   <= 1'b1;
                            end
                        end else if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            bus.mem_write <= 1'b1;
                            bus.mem_addr  <= {tags[idx], idx};
                            bus.mem_wdata <= data[idx];
                        end else begin
                            state        <= ALLOCATE;
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= {req_tag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state         <= ALLOCATE;
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
                        bus.mem_addr  <= {req_tag, idx};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        state        <= IDLE;
                        bus.mem_read <= 1'b0;
                        data[idx]    <= bus.mem_rdata;
                        tags[idx]    <= req_tag;
                        valid[idx]   <= 1'b1;
                        dirty[idx]   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // post_fill marks the IDLE cycle right after a fill, whose hit completes an already-counted miss.
    logic post_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            post_fill <= 1'b0;
        end else begin
            if (state == ALLOCATE && bus.mem_ready)
                post_fill <= 1'b1;
            else if (state == IDLE)
                post_fill <= 1'b0;
            if (state == IDLE && req) begin
                if (hit && !post_fill && hit_cnt != '1)
                    hit_cnt <= hit_cnt + 32'd1;
                if (!hit && miss_cnt != '1)
                    miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_direct_wb.sv
// Self-checking bench for dcache_direct_wb: a 4-cycle block memory responder,
// a flat word reference model and a read-data scoreboard queue.
module tb_dcache_direct_wb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_direct_wb_if bus ();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    dcache_direct_wb #(.INDEX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                         .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
    dcache_direct_wb #(.INDEX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_ev_t;

    mem_ev_t      log_q [$];
    logic [31:0]  exp_q [$];
    logic [127:0] model [logic [27:0]];
    logic [31:0]  ref_w [logic [29:0]];

    function automatic logic [31:0] pat(input logic [29:0] a);
        if (a == 30'h5) return 32'hDEADBEEF;
        return {2'b00, a} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] init_blk(input logic [27:0] b);
        logic [127:0] blk;
        for (int unsigned w = 0; w < 4; w++)
            blk[w*32 +: 32] = pat({b, 2'(w)});
        return blk;
    endfunction

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        if (ref_w.exists(a)) return ref_w[a];
        return pat(a);
    endfunction

    // Presents one request, serves memory with 4-cycle ready latency, returns stall cycles.
    task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                          output int cycles, output logic first_stall, output logic [31:0] rd);
        int lat;
        log_q.delete();
        @(negedge clk);
        bus.proc_read  = !wr;
        bus.proc_write = wr;
        bus.proc_addr  = addr;
        bus.proc_wdata = wd;
        #1;
        first_stall = bus.proc_stall;
        cycles = 0;
        lat = 0;
        while (bus.proc_stall && cycles < 200) begin
            if (bus.mem_read || bus.mem_write) begin
                if (lat == 0)
                    log_q.push_back('{bus.mem_write, bus.mem_addr, bus.mem_wdata});
                lat++;
                if (lat == 4) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_read) begin
                        if (!model.exists(bus.mem_addr)) model[bus.mem_addr] = init_blk(bus.mem_addr);
                        bus.mem_rdata = model[bus.mem_addr];
                    end else begin
                        model[bus.mem_addr] = bus.mem_wdata;
                    end
                end
            end
            @(negedge clk);
            if (bus.mem_ready) lat = 0;
            bus.mem_ready = 1'b0;
            #1;
            cycles++;
        end
        if (cycles >= 200) begin
            checks++; errors++;
            $display("FAIL access_timeout addr=%h: stall still high after %0d cycles, required low", addr, cycles);
        end
        rd = bus.proc_rdata;
        if (wr) ref_w[addr] = wd;
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'h0 || bus.mem_read !== 1'b0 ||
            bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0 || bus.mem_wdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b rdata=%h mrd=%b mwr=%b maddr=%h mwd=%h, required all zero",
                     bus.proc_stall, bus.proc_rdata, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_read_miss();
        int cyc; logic fs; logic [31:0] rd, ex;
        exp_q.push_back(ref_read(30'h5));
        access(1'b0, 30'h5, 32'h0, cyc, fs, rd);
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL miss_first_stall: got %b required 1", fs); end
        checks++;
        if (log_q.size() != 1 || log_q[0].wr !== 1'b0 || log_q[0].addr !== 28'h1) begin
            errors++; $display("FAIL clean_miss_mem_req: got %0d events, required one read of 0000001", log_q.size());
        end
        checks++;
        if (cyc != 5) begin errors++; $display("FAIL clean_miss_latency: got %0d required 5", cyc); end
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL clean_miss_rdata: got %h required %h", rd, ex); end
    endtask

    task automatic test_read_hit();
        int cyc; logic fs; logic [31:0] rd, ex;
        exp_q.push_back(ref_read(30'h6));
        access(1'b0, 30'h6, 32'h0, cyc, fs, rd);
        checks++;
        if (cyc != 0 || log_q.size() != 0) begin
            errors++; $display("FAIL read_hit_latency: got %0d cycles %0d mem events, required 0 and 0", cyc, log_q.size());
        end
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL read_hit_rdata: got %h required %h", rd, ex); end
    endtask

    task automatic test_dirty_miss();
        int cyc; logic fs; logic [31:0] rd, ex;
        access(1'b1, 30'h4, 32'h12345678, cyc, fs, rd);
        checks++;
        if (cyc != 0 || log_q.size() != 0) begin
            errors++; $display("FAIL write_hit: got %0d cycles %0d mem events, required 0 and 0", cyc, log_q.size());
        end
        exp_q.push_back(ref_read(30'h24));
        access(1'b0, 30'h24, 32'h0, cyc, fs, rd);
        checks++;
        if (log_q.size() != 2) begin
            errors++; $display("FAIL dirty_miss_events: got %0d required 2", log_q.size());
        end else begin
            checks++;
            if (log_q[0].wr !== 1'b1 || log_q[0].addr !== 28'h1 || log_q[0].data[31:0] !== 32'h12345678) begin
                errors++; $display("FAIL writeback: got wr=%b addr=%h w0=%h required 1 0000001 12345678",
                                   log_q[0].wr, log_q[0].addr, log_q[0].data[31:0]);
            end
            checks++;
            if (log_q[1].wr !== 1'b0 || log_q[1].addr !== 28'h9) begin
                errors++; $display("FAIL refill_after_wb: got wr=%b addr=%h required 0 0000009", log_q[1].wr, log_q[1].addr);
            end
        end
        checks++;
        if (cyc != 9) begin errors++; $display("FAIL dirty_miss_latency: got %0d required 9", cyc); end
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL dirty_miss_rdata: got %h required %h", rd, ex); end
    endtask

`ifdef DCACHE_PERF_CNT_EN
    task automatic test_perf_cnt();
        checks++;
        if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
            errors++; $display("FAIL perf_cnt: got hit=%0d miss=%0d required 2 2", hit_cnt, miss_cnt);
        end
    endtask
`endif

    task automatic test_write_miss();
        int cyc; logic fs; logic [31:0] rd, ex;
        access(1'b1, 30'h40, 32'hCAFEF00D, cyc, fs, rd);
        checks++;
        if (log_q.size() != 1 || log_q[0].wr !== 1'b0 || log_q[0].addr !== 28'h10 || cyc != 5) begin
            errors++; $display("FAIL write_miss_clean: got %0d events cycles=%0d, required one read of 0000010 and 5", log_q.size(), cyc);
        end
        exp_q.push_back(ref_read(30'h40));
        access(1'b0, 30'h40, 32'h0, cyc, fs, rd);
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex || cyc != 0) begin errors++; $display("FAIL write_miss_update: got %h cycles=%0d required %h 0", rd, cyc, ex); end
        exp_q.push_back(ref_read(30'h60));
        access(1'b0, 30'h60, 32'h0, cyc, fs, rd);
        checks++;
        if (log_q.size() != 2 || log_q[0].wr !== 1'b1 || log_q[0].addr !== 28'h10 ||
            log_q[0].data[31:0] !== 32'hCAFEF00D || log_q[1].addr !== 28'h18) begin
            errors++; $display("FAIL write_miss_writeback: got %0d events, required wb of 0000010 with cafef00d then read 0000018", log_q.size());
        end
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL conflict_rdata: got %h required %h", rd, ex); end
    endtask

    task automatic test_reset_abort();
        int cyc; logic fs; logic [31:0] rd, ex;
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h84;
        @(negedge clk);
        #1;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h21) begin
            errors++; $display("FAIL abort_setup: got mrd=%b addr=%h required 1 0000021", bus.mem_read, bus.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL abort_async_drop: got mem_read=%b required 0", bus.mem_read); end
        bus.proc_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(ref_read(30'h84));
        access(1'b0, 30'h84, 32'h0, cyc, fs, rd);
        checks++;
        if (cyc != 5 || log_q.size() != 1) begin
            errors++; $display("FAIL abort_remiss: got cycles=%0d events=%0d required 5 1", cyc, log_q.size());
        end
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex) begin errors++; $display("FAIL abort_rdata: got %h required %h", rd, ex); end
        exp_q.push_back(ref_read(30'h4));
        access(1'b0, 30'h4, 32'h0, cyc, fs, rd);
        ex = exp_q.pop_front();
        checks++;
        if (rd !== ex || cyc != 5) begin errors++; $display("FAIL written_back_data: got %h cycles=%0d required %h 5", rd, cyc, ex); end
    endtask

    initial begin
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        test_reset();
        test_clean_read_miss();
        test_read_hit();
        test_dirty_miss();
`ifdef DCACHE_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_write_miss();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
